// File: rtl/cdf_pkg.sv
// rtl/cdf_pkg.sv - shared widths, table geometry and reader state enum for the CDF read path
// Purpose: constants and types common to cdf_reader, its interface and its word FIFO.
// Ports: none (package).

package cdf_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 128;
  localparam int LANE_W         = 32;
  localparam int CDF_W          = 20;
  localparam int LANES_PER_WORD = 4;
  localparam int NUM_BINS       = 256;
  localparam int NUM_WORDS      = NUM_BINS / LANES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

  // Lane k of a packed word carries its CDF value in the low CDF_W bits of
  // the k-th LANE_W slice; the bits above are padding and ignored.
  function automatic logic [CDF_W-1:0] lane_value(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        lane);
    return word[lane*LANE_W +: CDF_W];
  endfunction

endpackage

// File: rtl/cdf_reader_if.sv
// rtl/cdf_reader_if.sv - memory read port and CDF output stream of the CDF reader
// Purpose: bundles the memory read bus and the valid/ready CDF stream.
// Signals: read_enable/read_address (reader -> memory), read_bus (memory -> reader),
//          cdf_value/cdf_bin/cdf_valid (reader -> consumer), cdf_ready (consumer -> reader).
// Modports: master = reader side, slave = memory + consumer side.

interface cdf_reader_if;
  import cdf_pkg::*;

  logic              read_enable;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_bus;
  logic [CDF_W-1:0]  cdf_value;
  logic [7:0]        cdf_bin;
  logic              cdf_valid;
  logic              cdf_ready;

  modport master (
    output read_enable, read_address, cdf_value, cdf_bin, cdf_valid,
    input  read_bus, cdf_ready
  );

  modport slave (
    input  read_enable, read_address, cdf_value, cdf_bin, cdf_valid,
    output read_bus, cdf_ready
  );

endinterface

// File: rtl/cdf_word_fifo.sv
// rtl/cdf_word_fifo.sv - 2-entry synchronous word FIFO between memory return and lane unpacker
// Purpose: absorbs the 1-cycle read latency and downstream backpressure.
// Ports: clock, reset (sync, active-high); push/push_data write the tail;
//        pop retires the head; head_data = oldest entry, next_data = entry behind it;
//        empty, count = occupancy (0..2).
// The caller never pushes when full nor pops when empty.

module cdf_word_fifo
  import cdf_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] next_data,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

  assign head_data = mem[rd_ptr];
  assign next_data = mem[~rd_ptr];
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/cdf_reader.sv
// rtl/cdf_reader.sv - fetches a 64-word packed CDF table and streams 256 CDF values
// Purpose: reads words base..base+63, unpacks 4 lanes per word, emits one bin per
//          handshake and flags any decrease between consecutive accepted values.
// Ports: clock, reset (sync, active-high); start + base_address begin a table read;
//        bus (cdf_reader_if.master) = memory read port and CDF output stream;
//        busy (start accepted .. done), done (1-cycle pulse), mono_err (sticky).

module cdf_reader
  import cdf_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_address,
  cdf_reader_if.master        bus,
  output logic                busy,
  output logic                done,
  output logic                mono_err
);

  reader_state_t     state;
  logic [ADDR_W-1:0] base_q;
  logic [6:0]        words_issued;
  logic              ret_valid;
  logic [1:0]        lane;
  logic [CDF_W-1:0]  prev_value;

  logic              handshake;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] next_data;
  logic              empty;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic [DATA_W-1:0] head_next;
  logic [1:0]        lane_next;
  logic              issue_ok;

  // Read data arrives the cycle after read_enable; ret_valid marks that cycle.
  // Because it is cleared by reset, a return for a pre-reset read is dropped.
  assign handshake = bus.cdf_valid && bus.cdf_ready;
  assign push      = ret_valid;
  assign pop       = handshake && (lane == 2'd3);

  cdf_word_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (bus.read_bus),
    .pop       (pop),
    .head_data (head_data),
    .next_data (next_data),
    .empty     (empty),
    .count     (count)
  );

  // Output registers are loaded from the FIFO's next-cycle head so that
  // cdf_valid/cdf_value are flops yet track the FIFO without a bubble.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (!push && pop) count_next = count - 2'd1;

    head_next = head_data;
    if (pop) begin
      // count==1 with a pop: the only possible new head is the returning word
      head_next = (count == 2'd2) ? next_data : bus.read_bus;
    end else if (empty) begin
      head_next = bus.read_bus;
    end

    lane_next = handshake ? lane + 2'd1 : lane;

    // Next cycle's outstanding read is the one issued this cycle; holding
    // buffered + outstanding below 2 means a return always finds a free slot.
    issue_ok = ({1'b0, count_next} + {2'b00, bus.read_enable}) < 3'd2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      base_q           <= '0;
      words_issued     <= '0;
      ret_valid        <= 1'b0;
      lane             <= 2'd0;
      prev_value       <= '0;
      bus.read_enable  <= 1'b0;
      bus.read_address <= '0;
      bus.cdf_valid    <= 1'b0;
      bus.cdf_value    <= '0;
      bus.cdf_bin      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mono_err         <= 1'b0;
    end else begin
      ret_valid       <= bus.read_enable;
      bus.read_enable <= 1'b0;
      done            <= 1'b0;
      lane            <= lane_next;

      bus.cdf_valid <= (count_next != 2'd0);
      if (count_next != 2'd0) begin
        bus.cdf_value <= lane_value(head_next, lane_next);
      end

      if (handshake) begin
        bus.cdf_bin <= bus.cdf_bin + 8'd1;
        prev_value  <= bus.cdf_value;
        if ((bus.cdf_bin != 8'd0) && (bus.cdf_value < prev_value)) begin
          mono_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state            <= FETCH;
            busy             <= 1'b1;
            base_q           <= base_address;
            bus.read_enable  <= 1'b1;
            bus.read_address <= base_address;
            words_issued     <= 7'd1;
            lane             <= 2'd0;
            bus.cdf_bin      <= 8'd0;
            mono_err         <= 1'b0;
          end
        end
        FETCH: begin
          if (issue_ok) begin
            bus.read_enable  <= 1'b1;
            bus.read_address <= base_q + {{(ADDR_W-7){1'b0}}, words_issued};
            words_issued     <= words_issued + 7'd1;
            if (words_issued == 7'(NUM_WORDS - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (handshake && (bus.cdf_bin == 8'(NUM_BINS - 1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_reader.sv
// tb/tb_cdf_reader.sv - directed self-checking bench for cdf_reader

module tb_cdf_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_address = 16'h0;
  logic        busy;
  logic        done;
  logic        mono_err;

  cdf_reader_if bus_if ();

  cdf_reader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_address (base_address),
    .bus          (bus_if),
    .busy         (busy),
    .done         (done),
    .mono_err     (mono_err)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc = 0;
  int t0  = 0;

  logic [19:0] tbl [256];
  logic        garbage = 1'b0;
  logic [15:0] tb_base = 16'h0;

  int acc_bin[$];
  int acc_val[$];
  int acc_rel[$];
  int rd_addr[$];
  int rd_rel[$];
  int done_cnt, done_rel, busy_rel1, mono_rel, stall_bad;
  logic mono_at_done;
  logic prev_stall;
  logic [19:0] prev_val;
  logic [7:0]  prev_bin;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] build_word(input logic [15:0] widx);
    logic [127:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = 4 * int'(widx[5:0]) + k;
      w[32*k +: 20]    = tbl[idx[7:0]];
      w[32*k+20 +: 12] = garbage ? 12'hFFF : 12'h000;
    end
    return w;
  endfunction

  // Memory model: one-cycle read latency, addressed relative to the table base.
  initial bus_if.read_bus = '0;
  always @(posedge clock) begin
    if (bus_if.read_enable) bus_if.read_bus <= build_word(bus_if.read_address - tb_base);
  end

  always @(negedge clock) begin
    int rel;
    rel = cyc - t0;
    if (bus_if.cdf_valid && bus_if.cdf_ready) begin
      acc_bin.push_back(int'(bus_if.cdf_bin));
      acc_val.push_back(int'(bus_if.cdf_value));
      acc_rel.push_back(rel);
    end
    if (bus_if.read_enable) begin
      rd_addr.push_back(int'(bus_if.read_address));
      rd_rel.push_back(rel);
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
      mono_at_done = mono_err;
    end
    if (rel == 1) busy_rel1 = int'(busy);
    if (mono_err && mono_rel < 0) mono_rel = rel;
    if (prev_stall && (!bus_if.cdf_valid || bus_if.cdf_value != prev_val ||
                       bus_if.cdf_bin != prev_bin)) stall_bad++;
    prev_stall = bus_if.cdf_valid && !bus_if.cdf_ready;
    prev_val   = bus_if.cdf_value;
    prev_bin   = bus_if.cdf_bin;
  end

  task automatic clear_logs();
    acc_bin.delete(); acc_val.delete(); acc_rel.delete();
    rd_addr.delete(); rd_rel.delete();
    done_cnt = 0; done_rel = -1; busy_rel1 = -1; mono_rel = -1;
    stall_bad = 0; prev_stall = 1'b0; mono_at_done = 1'b0;
  endtask

  task automatic run_pass(input logic [15:0] base, input bit rand_ready,
                          input bit extra_start, output bit ok);
    clear_logs();
    @(posedge clock); #1;
    t0 = cyc; tb_base = base; base_address = base; start = 1'b1;
    bus_if.cdf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (extra_start && (cyc - t0) == 40) begin
        start = 1'b1;
        base_address = 16'h5555;
      end
      bus_if.cdf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    ok = (done_cnt != 0);
    @(posedge clock); #1;
    bus_if.cdf_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.cdf_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_cnt++; if (bus_if.read_enable !== 1'b0) $display("FAIL rst_read_enable got %b want 0", bus_if.read_enable); else pass_cnt++;
    check_cnt++; if (bus_if.read_address !== 16'h0) $display("FAIL rst_read_address got %h want 0", bus_if.read_address); else pass_cnt++;
    check_cnt++; if (bus_if.cdf_valid !== 1'b0) $display("FAIL rst_cdf_valid got %b want 0", bus_if.cdf_valid); else pass_cnt++;
    check_cnt++; if (bus_if.cdf_value !== 20'h0) $display("FAIL rst_cdf_value got %h want 0", bus_if.cdf_value); else pass_cnt++;
    check_cnt++; if (bus_if.cdf_bin !== 8'h0) $display("FAIL rst_cdf_bin got %h want 0", bus_if.cdf_bin); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else pass_cnt++;
    check_cnt++; if (mono_err !== 1'b0) $display("FAIL rst_mono_err got %b want 0", mono_err); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok; int bad; int first;
    for (int b = 0; b < 256; b++) tbl[b] = 20'(b * 4);
    garbage = 1'b0;
    run_pass(16'h0100, 1'b0, 1'b0, ok);
    check_cnt++; if (!ok) $display("FAIL basic_done_timeout got no done want done"); else pass_cnt++;
    check_cnt++; if (rd_addr.size() !== 64) $display("FAIL basic_read_count got %0d want 64", rd_addr.size()); else pass_cnt++;
    bad = 0; first = -1;
    foreach (rd_addr[i]) if (rd_addr[i] !== 16'h0100 + i) begin bad++; if (first < 0) first = i; end
    check_cnt++; if (bad !== 0) $display("FAIL basic_addresses got %0d wrong (first idx %0d) want 0 wrong", bad, first); else pass_cnt++;
    check_cnt++; if (rd_rel.size() == 0 || rd_rel[0] !== 1) $display("FAIL basic_first_read_cycle got %0d want 1", rd_rel.size() ? rd_rel[0] : -1); else pass_cnt++;
    check_cnt++; if (busy_rel1 !== 1) $display("FAIL basic_busy_t1 got %0d want 1", busy_rel1); else pass_cnt++;
    check_cnt++; if (acc_val.size() !== 256) $display("FAIL basic_bin_count got %0d want 256", acc_val.size()); else pass_cnt++;
    bad = 0; first = -1;
    foreach (acc_val[i]) if (acc_bin[i] !== i || acc_val[i] !== i * 4 || acc_rel[i] !== 3 + i) begin bad++; if (first < 0) first = i; end
    check_cnt++; if (bad !== 0) $display("FAIL basic_stream got %0d wrong (first idx %0d) want 0 wrong", bad, first); else pass_cnt++;
    check_cnt++; if (done_rel !== 259) $display("FAIL basic_done_cycle got %0d want 259", done_rel); else pass_cnt++;
    check_cnt++; if (done_cnt !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
    check_cnt++; if (mono_at_done !== 1'b0) $display("FAIL basic_mono_err got %b want 0", mono_at_done); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok; int bad; int first;
    for (int b = 0; b < 256; b++) tbl[b] = 20'(b * 4);
    garbage = 1'b0;
    run_pass(16'h0100, 1'b1, 1'b1, ok);
    check_cnt++; if (!ok) $display("FAIL bp_done_timeout got no done want done"); else pass_cnt++;
    check_cnt++; if (acc_val.size() !== 256) $display("FAIL bp_bin_count got %0d want 256", acc_val.size()); else pass_cnt++;
    bad = 0; first = -1;
    foreach (acc_val[i]) if (acc_bin[i] !== i || acc_val[i] !== i * 4) begin bad++; if (first < 0) first = i; end
    check_cnt++; if (bad !== 0) $display("FAIL bp_stream got %0d wrong (first idx %0d) want 0 wrong", bad, first); else pass_cnt++;
    check_cnt++; if (stall_bad !== 0) $display("FAIL bp_stall_stable got %0d unstable cycles want 0", stall_bad); else pass_cnt++;
    check_cnt++; if (acc_rel.size() == 0 || done_rel !== acc_rel[acc_rel.size()-1] + 1)
      $display("FAIL bp_done_after_last got %0d want %0d", done_rel, acc_rel.size() ? acc_rel[acc_rel.size()-1] + 1 : -1); else pass_cnt++;
    bad = 0;
    foreach (rd_addr[i]) if (rd_addr[i] !== 16'h0100 + i) bad++;
    check_cnt++; if (rd_addr.size() !== 64 || bad !== 0) $display("FAIL bp_addresses got %0d reads %0d wrong want 64 reads 0 wrong", rd_addr.size(), bad); else pass_cnt++;
  endtask

  task automatic test_wrap_garbage();
    bit ok; int bad; int first;
    for (int b = 0; b < 256; b++) tbl[b] = 20'h80000 + 20'(b * 4);
    garbage = 1'b1;
    run_pass(16'hFFF0, 1'b0, 1'b0, ok);
    check_cnt++; if (!ok) $display("FAIL wrap_done_timeout got no done want done"); else pass_cnt++;
    bad = 0; first = -1;
    foreach (rd_addr[i]) if (rd_addr[i] !== ((16'hFFF0 + i) & 16'hFFFF)) begin bad++; if (first < 0) first = i; end
    check_cnt++; if (rd_addr.size() !== 64 || bad !== 0) $display("FAIL wrap_addresses got %0d reads %0d wrong (first %0d) want 64 reads 0 wrong", rd_addr.size(), bad, first); else pass_cnt++;
    bad = 0; first = -1;
    foreach (acc_val[i]) if (acc_bin[i] !== i || acc_val[i] !== 32'h80000 + i * 4) begin bad++; if (first < 0) first = i; end
    check_cnt++; if (acc_val.size() !== 256 || bad !== 0) $display("FAIL wrap_values got %0d bins %0d wrong (first %0d) want 256 bins 0 wrong", acc_val.size(), bad, first); else pass_cnt++;
    check_cnt++; if (done_rel !== 259) $display("FAIL wrap_done_cycle got %0d want 259", done_rel); else pass_cnt++;
    garbage = 1'b0;
  endtask

  task automatic test_mono();
    bit ok;
    for (int b = 0; b < 256; b++) tbl[b] = (b < 99) ? 20'd0 : 20'(1000 + b);
    tbl[99]  = 20'd9;
    tbl[100] = 20'd5;
    run_pass(16'h0400, 1'b0, 1'b0, ok);
    check_cnt++; if (!ok) $display("FAIL mono_done_timeout got no done want done"); else pass_cnt++;
    check_cnt++; if (mono_rel !== 104) $display("FAIL mono_rise_cycle got %0d want 104", mono_rel); else pass_cnt++;
    check_cnt++; if (mono_at_done !== 1'b1) $display("FAIL mono_sticky_at_done got %b want 1", mono_at_done); else pass_cnt++;
    check_cnt++; if (acc_val.size() < 101 || acc_val[100] !== 5) $display("FAIL mono_bin100_value got %0d want 5", acc_val.size() > 100 ? acc_val[100] : -1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok; bit found; int bad; int first;
    for (int b = 0; b < 256; b++) tbl[b] = 20'(b * 4);
    clear_logs();
    @(posedge clock); #1;
    t0 = cyc; tb_base = 16'h0100; base_address = 16'h0100; start = 1'b1;
    bus_if.cdf_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (bus_if.cdf_valid && bus_if.cdf_bin >= 8'd70 && bus_if.read_enable) found = 1'b1;
    end
    check_cnt++; if (!found) $display("FAIL rmid_reach_bin70 got not reached want reached"); else pass_cnt++;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_cnt++;
    if ({bus_if.read_enable, bus_if.read_address, bus_if.cdf_valid, bus_if.cdf_value,
         bus_if.cdf_bin, busy, done, mono_err} !== '0)
      $display("FAIL rmid_outputs_zero got re=%b ra=%h v=%b val=%h bin=%h busy=%b done=%b me=%b want all 0",
               bus_if.read_enable, bus_if.read_address, bus_if.cdf_valid, bus_if.cdf_value,
               bus_if.cdf_bin, busy, done, mono_err);
    else pass_cnt++;
    run_pass(16'h0300, 1'b0, 1'b0, ok);
    check_cnt++; if (!ok) $display("FAIL rmid_done_timeout got no done want done"); else pass_cnt++;
    bad = 0; first = -1;
    foreach (acc_val[i]) if (acc_bin[i] !== i || acc_val[i] !== i * 4 || acc_rel[i] !== 3 + i) begin bad++; if (first < 0) first = i; end
    check_cnt++; if (acc_val.size() !== 256 || bad !== 0) $display("FAIL rmid_second_pass got %0d bins %0d wrong (first %0d) want 256 bins 0 wrong", acc_val.size(), bad, first); else pass_cnt++;
    bad = 0;
    foreach (rd_addr[i]) if (rd_addr[i] !== 16'h0300 + i) bad++;
    check_cnt++; if (rd_addr.size() !== 64 || bad !== 0) $display("FAIL rmid_addresses got %0d reads %0d wrong want 64 reads 0 wrong", rd_addr.size(), bad); else pass_cnt++;
    check_cnt++; if (done_rel !== 259) $display("FAIL rmid_done_cycle got %0d want 259", done_rel); else pass_cnt++;
  endtask

  initial begin
    bus_if.cdf_ready = 1'b1;
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_garbage();
    test_mono();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
